class_vec_seq_ctrl: RTL and testbench

Sequencer for the class hypervector generator. On a start pulse it walks every (frame_index, class) address of the generator in frame-major order. It registers each 64-bit frame and streams it to the similarity stage over a valid/ready handshake, tagged with class id, frame index and end-of-sweep markers. It sits between the inference control FSM and the associative-search datapath.

---
 rtl/class_hvec_pkg.sv | 21 ++
 rtl/class_vec_seq_ctrl_addr_cnt.sv | 80 ++++++++
 rtl/class_vec_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_class_vec_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/class_hvec_pkg.sv
// Shared sizing defaults and sequencer state encoding for the
// class hypervector sequencer.
package class_hvec_pkg;

    localparam int NUM_CLASSES = 8;
    localparam int NUM_FRAMES  = 3;
    localparam int FRAME_W     = 64;
    localparam int CLASS_ID_W  = 3;
    localparam int FRAME_IDX_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN
    } seq_state_t;

endpackage

// File: rtl/class_vec_seq_ctrl_addr_cnt.sv
// class_addr_cnt: nested class/frame address counter with wrap,
// last-flag generation and skipping of masked-off classes.
module class_addr_cnt
    import class_hvec_pkg::*;
#(
    parameter int NUM_CLASSES = class_hvec_pkg::NUM_CLASSES,
    parameter int NUM_FRAMES  = class_hvec_pkg::NUM_FRAMES,
    parameter int CLASS_ID_W  = class_hvec_pkg::CLASS_ID_W,
    parameter int FRAME_IDX_W = class_hvec_pkg::FRAME_IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_adv,
    input  logic [NUM_CLASSES-1:0] i_mask,
    output logic [CLASS_ID_W-1:0]  o_id,
    output logic [FRAME_IDX_W-1:0] o_idx,
    output logic                   o_last_class,
    output logic                   o_last
);

    logic [NUM_CLASSES-1:0] r_mask;
    logic [CLASS_ID_W-1:0]  r_id;
    logic [FRAME_IDX_W-1:0] r_idx;
    logic [CLASS_ID_W-1:0]  w_first;
    logic [CLASS_ID_W-1:0]  w_last_en;
    logic [CLASS_ID_W-1:0]  w_next;

    function automatic logic [CLASS_ID_W-1:0] first_en(
        input logic [NUM_CLASSES-1:0] m
    );
        first_en = '0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--)
            if (m[i]) first_en = CLASS_ID_W'(i);
    endfunction

    function automatic logic [CLASS_ID_W-1:0] last_en(
        input logic [NUM_CLASSES-1:0] m
    );
        last_en = '0;
        for (int i = 0; i < NUM_CLASSES; i++)
            if (m[i]) last_en = CLASS_ID_W'(i);
    endfunction

    assign w_first   = first_en(r_mask);
    assign w_last_en = last_en(r_mask);

    // Lowest enabled class above the current one; lets a skip take one cycle.
    always_comb begin
        w_next = w_first;
        for (int i = NUM_CLASSES - 1; i >= 0; i--)
            if (r_mask[i] && (i > int'(r_id))) w_next = CLASS_ID_W'(i);
    end

    assign o_id         = r_id;
    assign o_idx        = r_idx;
    assign o_last_class = (r_id == w_last_en);
    assign o_last       = o_last_class &&
                          (r_idx == FRAME_IDX_W'(NUM_FRAMES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
            r_id   <= '0;
            r_idx  <= '0;
        end else if (i_start) begin
            r_mask <= i_mask;
            r_id   <= first_en(i_mask);
            r_idx  <= '0;
        end else if (i_adv) begin
            if (o_last_class) begin
                r_id  <= w_first;
                r_idx <= o_last ? '0 : r_idx + FRAME_IDX_W'(1);
            end else begin
                r_id  <= w_next;
            end
        end
    end

endmodule

// File: rtl/class_vec_seq_ctrl.sv
// Sweeps the class hypervector generator frame-major and streams each frame
// over valid/ready. Optional class skipping under CLASS_VEC_MASK_EN.
module class_vec_seq_ctrl
    import class_hvec_pkg::*;
#(
    parameter int NUM_CLASSES = class_hvec_pkg::NUM_CLASSES,
    parameter int NUM_FRAMES  = class_hvec_pkg::NUM_FRAMES,
    parameter int FRAME_W     = class_hvec_pkg::FRAME_W,
    parameter int CLASS_ID_W  = class_hvec_pkg::CLASS_ID_W,
    parameter int FRAME_IDX_W = class_hvec_pkg::FRAME_IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [CLASS_ID_W-1:0]  gen_frame_id,
    output logic [FRAME_IDX_W-1:0] gen_frame_index,
    input  logic [FRAME_W-1:0]     gen_vec_in,
`ifdef CLASS_VEC_MASK_EN
    input  logic [NUM_CLASSES-1:0] class_mask,
`endif
    output logic [FRAME_W-1:0]     out_vec,
    output logic [CLASS_ID_W-1:0]  out_class_id,
    output logic [FRAME_IDX_W-1:0] out_frame_index,
    output logic                   out_last_class,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready
);

    seq_state_t             r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_valid;
    logic                   r_last;
    logic                   r_last_class;
    logic [FRAME_W-1:0]     r_vec;
    logic [CLASS_ID_W-1:0]  r_cls;
    logic [FRAME_IDX_W-1:0] r_idx;

    logic [NUM_CLASSES-1:0] w_mask;
    logic                   w_any;
    logic                   w_start;
    logic                   w_load;
    logic                   w_adv;
    logic                   w_last_class;
    logic                   w_last;

`ifdef CLASS_VEC_MASK_EN
    assign w_mask = class_mask;
`else
    assign w_mask = '1;
`endif

    assign w_any   = |w_mask;
    assign w_start = (r_state == S_IDLE) && start && !abort;
    assign w_load  = (r_state == S_RUN) && (!r_valid || out_ready);
    assign w_adv   = w_load && !abort;

    class_addr_cnt #(
        .NUM_CLASSES (NUM_CLASSES),
        .NUM_FRAMES  (NUM_FRAMES),
        .CLASS_ID_W  (CLASS_ID_W),
        .FRAME_IDX_W (FRAME_IDX_W)
    ) u_addr_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_adv        (w_adv),
        .i_mask       (w_mask),
        .o_id         (gen_frame_id),
        .o_idx        (gen_frame_index),
        .o_last_class (w_last_class),
        .o_last       (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_last_class <= 1'b0;
            r_vec        <= '0;
            r_cls        <= '0;
            r_idx        <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
                r_valid      <= 1'b0;
                r_last       <= 1'b0;
                r_last_class <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        // An empty mask finishes at once without going busy.
                        if (start) begin
                            if (w_any) begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b1;
                            end else begin
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_load) begin
                            r_vec        <= gen_vec_in;
                            r_cls        <= gen_frame_id;
                            r_idx        <= gen_frame_index;
                            r_last       <= w_last;
                            r_last_class <= w_last_class;
                            r_valid      <= 1'b1;
                            if (w_last) r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (r_valid && out_ready) begin
                            r_valid      <= 1'b0;
                            r_last       <= 1'b0;
                            r_last_class <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign out_vec         = r_vec;
    assign out_class_id    = r_cls;
    assign out_frame_index = r_idx;
    assign out_last_class  = r_last_class;
    assign out_last        = r_last;
    assign out_valid       = r_valid;

endmodule

// File: tb/tb_class_vec_seq_ctrl.sv
// Directed bench for class_vec_seq_ctrl: vector table for handshake and
// abort timing plus full sweeps (stall, reset, CLASS_VEC_MASK_EN mask).
module tb_class_vec_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [2:0]  gen_frame_id;
    logic [1:0]  gen_frame_index;
    logic [63:0] gen_vec_in;
    logic [7:0]  mask_tb;
    logic [63:0] out_vec;
    logic [2:0]  out_class_id;
    logic [1:0]  out_frame_index;
    logic        out_last_class;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int n_pass;
    int n_total;

    function automatic logic [63:0] gen_model(input logic [2:0] c,
                                              input logic [1:0] f);
        gen_model = {16'hC1A5, 13'd0, c, 14'd0, f,
                     16'h5A00 ^ {11'd0, c, f}};
    endfunction

    assign gen_vec_in = gen_model(gen_frame_id, gen_frame_index);

    class_vec_seq_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .gen_frame_id    (gen_frame_id),
        .gen_frame_index (gen_frame_index),
        .gen_vec_in      (gen_vec_in),
`ifdef CLASS_VEC_MASK_EN
        .class_mask      (mask_tb),
`endif
        .out_vec         (out_vec),
        .out_class_id    (out_class_id),
        .out_frame_index (out_frame_index),
        .out_last_class  (out_last_class),
        .out_last        (out_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] got,
                         input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        check({nm, " ctl"},
              128'({busy, done, out_valid, out_last, out_last_class,
                    gen_frame_id, gen_frame_index,
                    out_class_id, out_frame_index}),
              128'(0));
        check({nm, " vec"}, 128'(out_vec), 128'(0));
    endtask

    // Runs one sweep from IDLE using mask_tb; beat n must match the n-th
    // enabled (class, frame) pair until it is accepted.
    task automatic sweep(input bit tog, input int exp_done, input string nm);
        logic [4:0] q_tag[$];
        int n;
        int done_cyc;
        int first_cyc;
        int last_en;
        logic done_busy;
        last_en   = 0;
        n         = 0;
        done_cyc  = -1;
        first_cyc = -1;
        done_busy = 1'b1;
        for (int c = 0; c < 8; c++)
            if (mask_tb[c]) last_en = c;
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < 8; c++)
                if (mask_tb[c]) q_tag.push_back({3'(c), 2'(f)});
        start     = 1'b1;
        abort     = 1'b0;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 120 && done_cyc < 0; cyc++) begin
            out_ready = tog ? (cyc % 2 == 0) : 1'b1;
            if (done) begin
                done_cyc  = cyc;
                done_busy = busy;
            end
            if (cyc == exp_done - 1)
                check({nm, " busy_before_done"}, 128'(busy), 128'(1));
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (n < q_tag.size()) begin
                    check($sformatf("%s beat%0d tag", nm, n),
                          128'({out_class_id, out_frame_index}),
                          128'(q_tag[n]));
                    check($sformatf("%s beat%0d vec", nm, n),
                          128'(out_vec),
                          128'(gen_model(q_tag[n][4:2], q_tag[n][1:0])));
                    check($sformatf("%s beat%0d flags", nm, n),
                          128'({out_last, out_last_class}),
                          128'({n == q_tag.size() - 1,
                                q_tag[n][4:2] == 3'(last_en)}));
                    if (out_ready) n++;
                end else begin
                    check({nm, " extra_beat"}, 128'(n),
                          128'(q_tag.size() - 1));
                end
            end
            tick();
        end
        check({nm, " done_cycle"}, 128'(done_cyc), 128'(exp_done));
        check({nm, " beats"}, 128'(n), 128'(q_tag.size()));
        check({nm, " busy_at_done"}, 128'(done_busy), 128'(0));
        if (q_tag.size() > 0)
            check({nm, " first_beat_cycle"}, 128'(first_cyc), 128'(2));
        check({nm, " done_pulse_end"},
              128'({done, busy, out_valid}), 128'(0));
    endtask

    typedef struct {
        logic       st;
        logic       ab;
        logic       rdy;
        logic       busy;
        logic       vld;
        logic       dn;
        logic       chk_tag;
        logic [4:0] tag;
        logic       chk_gen;
        logic [4:0] gtag;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n;
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        mask_tb   = 8'hFF;

        // start, abort, ready -> busy, valid, done, out tag, gen address
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 1'b1, 5'h00};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'h00, 1'b1, 5'h04};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'h00, 1'b1, 5'h04};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'h04, 1'b1, 5'h08};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'h08, 1'b1, 5'h0C};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 5'h00};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 5'h00};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 5'h00};

        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            start     = tbl[i].st;
            abort     = tbl[i].ab;
            out_ready = tbl[i].rdy;
            tick();
            check($sformatf("vec%0d ctl", i),
                  128'({busy, out_valid, done}),
                  128'({tbl[i].busy, tbl[i].vld, tbl[i].dn}));
            if (tbl[i].chk_tag) begin
                check($sformatf("vec%0d tag", i),
                      128'({out_class_id, out_frame_index}),
                      128'(tbl[i].tag));
                check($sformatf("vec%0d vec", i), 128'(out_vec),
                      128'(gen_model(tbl[i].tag[4:2], tbl[i].tag[1:0])));
            end
            if (tbl[i].chk_gen)
                check($sformatf("vec%0d gen", i),
                      128'({gen_frame_id, gen_frame_index}),
                      128'(tbl[i].gtag));
        end
        start = 1'b0;
        abort = 1'b0;

        sweep(1'b0, 26, "full");
        sweep(1'b1, 49, "toggle");

        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && n < 10; k++) begin
            if (out_valid && out_ready) n++;
            tick();
        end
        check("midrst beats_before", 128'(n), 128'(10));
        #3 rst = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("midrst held");
        #2 rst = 1'b0;
        tick();
        sweep(1'b0, 26, "after_rst");

`ifdef CLASS_VEC_MASK_EN
        mask_tb = 8'b1000_0001;
        sweep(1'b0, 8, "mask81");
        mask_tb = 8'h00;
        sweep(1'b0, 1, "mask00");
        mask_tb = 8'hFF;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
